segment_scan_driver: RTL



---
 rtl/segment_pkg.sv | 48 ++++
 rtl/segment_scan_timer.sv | 43 ++++
 rtl/segment_scan_driver.sv | 105 ++++++++++
 3 files changed

// File: rtl/segment_pkg.sv
// segment_pkg: shared 7-segment types, hex decode and leading-zero mask helpers
package segment_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK  = 7'h7F;
    localparam int   MAX_DIGITS = 16;

    function automatic seg_t base16_to_segment(input logic [3:0] nibble);
        seg_t s;
        case (nibble)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0011000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Digit 0 is never blanked so an all-zero value still shows one "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] value,
                                                       input logic lz_en, input int num_digits);
        logic [MAX_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = MAX_DIGITS - 1; i > 0; i--) begin
            if (i < num_digits) begin
                zero_above = zero_above && (value[4*i +: 4] == 4'h0);
                m[i]       = lz_en && zero_above;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/segment_scan_timer.sv
// segment_scan_timer: slot counter and digit index for the display scan
module segment_scan_timer #(
    parameter int SCAN_W     = 16,
    parameter int NUM_DIGITS = 4,
    localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [IDX_W-1:0]  idx,
    output logic              slot_start,
    output logic              frame_wrap,
    output logic [SCAN_W-1:0] pwm_phase
);

    logic [SCAN_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              slot_end, last_digit;

    // Next counter/index; index advances when the slot counter wraps.
    always_comb begin
        slot_end   = &cnt_q;
        last_digit = idx_q == IDX_W'(NUM_DIGITS - 1);
        cnt_d      = cnt_q + 1'b1;
        idx_d      = slot_end ? (last_digit ? '0 : idx_q + 1'b1) : idx_q;
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx        = idx_q;
    assign slot_start = cnt_q == '0;
    assign frame_wrap = slot_end && last_digit;
    assign pwm_phase  = cnt_q;

endmodule

// File: rtl/segment_scan_driver.sv
// segment_scan_driver: multiplexed common-anode 7-segment driver with PWM and double buffering
module segment_scan_driver
    import segment_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_W     = 16,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic                    display_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [IDX_W-1:0]        idx;
    logic                    slot_start, frame_wrap;
    logic [SCAN_W-1:0]       pwm_phase;

    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, live_val_q, live_val_d, new_val;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, live_dp_q, live_dp_d, new_dp;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d, an_q, an_d;
    logic                    pend_lz_q, pend_lz_d, pend_vld_q, pend_vld_d, new_lz, take;
    logic [MAX_DIGITS-1:0]   mask_full;
    logic [BRIGHT_W-1:0]     brt_q, brt_d;
    seg_t                    seg_q, seg_d;
    logic                    dp_n_q, dp_n_d, fd_q, fd_d, lit;

    segment_scan_timer #(.SCAN_W(SCAN_W), .NUM_DIGITS(NUM_DIGITS)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .slot_start (slot_start),
        .frame_wrap (frame_wrap),
        .pwm_phase  (pwm_phase)
    );

    // Buffer handoff at frame boundaries plus PWM gating and registered pin values.
    always_comb begin
        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp : pend_dp_q;
        pend_lz_d  = load ? lz_en : pend_lz_q;
        pend_vld_d = !frame_wrap && (load || pend_vld_q);
        new_val    = load ? value : pend_val_q;
        new_dp     = load ? dp : pend_dp_q;
        new_lz     = load ? lz_en : pend_lz_q;
        take       = frame_wrap && (load || pend_vld_q);
        mask_full  = lz_mask((4*MAX_DIGITS)'(new_val), new_lz, NUM_DIGITS);
        live_val_d = take ? new_val : live_val_q;
        live_dp_d  = take ? new_dp : live_dp_q;
        mask_d     = take ? mask_full[NUM_DIGITS-1:0] : mask_q;
        brt_d      = slot_start ? brightness : brt_q;
        lit        = display_en && ((pwm_phase >> (SCAN_W - BRIGHT_W)) <= SCAN_W'(brt_d));
        an_d       = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
        seg_d      = (!lit || mask_q[idx]) ? SEG_BLANK : base16_to_segment(live_val_q[4*idx +: 4]);
        dp_n_d     = !(lit && live_dp_q[idx]);
        fd_d       = frame_wrap;
    end

    // All state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_lz_q  <= 1'b0;
            pend_vld_q <= 1'b0;
            live_val_q <= '0;
            live_dp_q  <= '0;
            mask_q     <= '0;
            brt_q      <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            dp_n_q     <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_lz_q  <= pend_lz_d;
            pend_vld_q <= pend_vld_d;
            live_val_q <= live_val_d;
            live_dp_q  <= live_dp_d;
            mask_q     <= mask_d;
            brt_q      <= brt_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_n_q     <= dp_n_d;
            fd_q       <= fd_d;
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_q;
    assign frame_done = fd_q;

endmodule
